sweep_sequencer: RTL

- Controller that sequences an external up/down bounce-counter datapath.
- Loads a start value, issues prescaled step pulses with a direction, and reverses at programmable low/high limits.
- Counts completed sweeps (lo→hi→lo) and stops after a programmed number.
- Sits between the front-panel/host control signals and the counter datapath; the datapath steps only on this block's step_en.

---
 rtl/sweep_sequencer_if.sv | 43 ++++
 rtl/sweep_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sweep_sequencer_if                                              |
// | Brief    : Control, config and datapath-handshake bundle of the sweep      |
// |            sequencer.                                                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface sweep_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int PWIDTH = 8,
    parameter int SWIDTH = 4
) ();
    logic              start;
    logic              stop;
    logic              pause;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [PWIDTH-1:0] period;
    logic [SWIDTH-1:0] sweeps;
    logic [WIDTH-1:0]  cnt_in;

    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              step_en;
    logic              dir;
    logic              busy;
    logic              done;
    logic              err;
    logic [SWIDTH-1:0] sweep_cnt;

    // Host and counter datapath side
    modport master (
        output start, stop, pause, lo, hi, period, sweeps, cnt_in,
        input  load, load_val, step_en, dir, busy, done, err, sweep_cnt
    );

    // Sequencer side
    modport slave (
        input  start, stop, pause, lo, hi, period, sweeps, cnt_in,
        output load, load_val, step_en, dir, busy, done, err, sweep_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sweep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sweep_sequencer                                                 |
// | Brief    : Sequences an external up/down bounce counter between latched    |
// |            lo/hi limits with a prescaled step rate and a sweep budget.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sweep_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PWIDTH = 8,
    parameter int SWIDTH = 4
) (
    input  wire logic        clk_1,
    input  wire logic        rst,
    sweep_sequencer_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LOAD     = 3'd1;
    localparam logic [2:0] c_ST_RUN_UP   = 3'd2;
    localparam logic [2:0] c_ST_RUN_DOWN = 3'd3;
    localparam logic [2:0] c_ST_PAUSED   = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

    localparam logic [PWIDTH-1:0] c_P_ONE = PWIDTH'(1);
    localparam logic [SWIDTH-1:0] c_S_ONE = SWIDTH'(1);

    logic [2:0]        r_state;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_hi;
    logic [PWIDTH-1:0] r_period;
    logic [SWIDTH-1:0] r_sweeps;
    logic [PWIDTH-1:0] r_presc;
    logic              r_paused_down;
    logic              r_load;
    logic [WIDTH-1:0]  r_load_val;
    logic              r_dir;
    logic              r_err;
    logic [SWIDTH-1:0] r_sweep_cnt;

    logic              w_run;
    logic              w_tick;
    logic              w_step_up;
    logic              w_step_dn;
    logic              w_limits_ok;
    logic              w_idle_like;
    logic [SWIDTH-1:0] w_sweep_next;
    logic [PWIDTH-1:0] w_period_eff;

    always_comb begin
        w_run        = (r_state == c_ST_RUN_UP) || (r_state == c_ST_RUN_DOWN);
        w_tick       = w_run && (r_presc == (r_period - c_P_ONE));
        w_step_up    = (r_state == c_ST_RUN_UP)   && w_tick && (bus.cnt_in < r_hi);
        w_step_dn    = (r_state == c_ST_RUN_DOWN) && w_tick && (bus.cnt_in > r_lo);
        w_limits_ok  = (bus.lo < bus.hi);
        w_idle_like  = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
        w_sweep_next = r_sweep_cnt + c_S_ONE;
        w_period_eff = (bus.period == '0) ? c_P_ONE : bus.period;
    end

    // Step decision is combinational so the datapath sees it on the same edge
    // the decision was made from; higher-priority controls suppress it.
    assign bus.step_en   = (w_step_up || w_step_dn) && !rst && !bus.stop && !bus.pause;
    assign bus.load      = r_load;
    assign bus.load_val  = r_load_val;
    assign bus.dir       = r_dir;
    assign bus.err       = r_err;
    assign bus.sweep_cnt = r_sweep_cnt;
    assign bus.busy      = (r_state == c_ST_LOAD)     || (r_state == c_ST_RUN_UP) ||
                           (r_state == c_ST_RUN_DOWN) || (r_state == c_ST_PAUSED);
    assign bus.done      = (r_state == c_ST_DONE);

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_lo          <= '0;
            r_hi          <= '0;
            r_period      <= '0;
            r_sweeps      <= '0;
            r_presc       <= '0;
            r_paused_down <= 1'b0;
            r_load        <= 1'b0;
            r_load_val    <= '0;
            r_dir         <= 1'b0;
            r_err         <= 1'b0;
            r_sweep_cnt   <= '0;
        end else begin
            r_load <= 1'b0;
            r_err  <= 1'b0;

            if (bus.stop) begin
                // Stop in IDLE is a no-op but still outranks start.
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE, c_ST_DONE: begin
                        if (bus.start) begin
                            if (w_limits_ok) begin
                                r_lo        <= bus.lo;
                                r_hi        <= bus.hi;
                                r_period    <= w_period_eff;
                                r_sweeps    <= bus.sweeps;
                                r_sweep_cnt <= '0;
                                r_load      <= 1'b1;
                                r_load_val  <= bus.lo;
                                r_state     <= c_ST_LOAD;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end

                    c_ST_LOAD: begin
                        r_presc <= '0;
                        r_dir   <= 1'b0;
                        r_state <= c_ST_RUN_UP;
                    end

                    c_ST_RUN_UP: begin
                        if (bus.pause) begin
                            r_paused_down <= 1'b0;
                            r_state       <= c_ST_PAUSED;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            // Reaching (or overshooting) hi spends this tick on the turn.
                            if (bus.cnt_in >= r_hi) begin
                                r_dir   <= 1'b1;
                                r_state <= c_ST_RUN_DOWN;
                            end
                        end else begin
                            r_presc <= r_presc + c_P_ONE;
                        end
                    end

                    c_ST_RUN_DOWN: begin
                        if (bus.pause) begin
                            r_paused_down <= 1'b1;
                            r_state       <= c_ST_PAUSED;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (bus.cnt_in <= r_lo) begin
                                r_sweep_cnt <= w_sweep_next;
                                if ((r_sweeps != '0) && (w_sweep_next == r_sweeps)) begin
                                    r_state <= c_ST_DONE;
                                end else begin
                                    r_dir   <= 1'b0;
                                    r_state <= c_ST_RUN_UP;
                                end
                            end
                        end else begin
                            r_presc <= r_presc + c_P_ONE;
                        end
                    end

                    c_ST_PAUSED: begin
                        if (!bus.pause) begin
                            r_state <= r_paused_down ? c_ST_RUN_DOWN : c_ST_RUN_UP;
                        end
                    end

                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
